mips_multicycle_control: RTL and testbench
==========================================

Name: mips_multicycle_control

Overview:
Main control FSM for the multicycle MIPS datapath. It produces the 5-bit ALUOp that alu_control decodes together with the function field. It sequences fetch, decode, execute, memory and writeback for the supported instruction subset, and stalls on a memory-ready handshake. Illegal encodings drive the FSM to a sticky trap state.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
Opcode  in  6  instruction bits [31:26], taken from the instruction register
Funct  in  6  instruction bits [5:0]
Zero  in  1  ALU zero flag
MemReady  in  1  memory completed the current read/write this cycle
ALUOp  out  5  operation class sent to alu_control
ALUSrcA  out  1  0=PC, 1=rs
ALUSrcB  out  2  0=rt, 1=const 4, 2=sign-ext imm, 3=sign-ext imm<<2
IorD  out  1  memory address select: 0=PC, 1=ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  load instruction register
PCWrite  out  1  load PC
PCSource  out  2  0=ALU result, 1=ALUOut, 2=jump target
RegDst  out  1  0=rt, 1=rd
MemtoReg  out  1  0=ALUOut, 1=MDR
RegWrite  out  1  register file write enable
Retire  out  1  one-cycle pulse when an instruction completes
RetiredCount  out  CNT_W  retired instructions, wraps at 2^CNT_W
Illegal  out  1  sticky trap flag
State  out  4  current state code, for debug

Behaviour:
- One clock domain, clk. reset is synchronous and active-low: state is sampled on the clk edge while reset=0.
- On reset: State=FETCH(0), RetiredCount=0, Illegal=0.
- While reset=0, MemRead, MemWrite, IRWrite, PCWrite, RegWrite and Retire are forced to 0. A reset mid-instruction abandons it with no partial writes.
- Outputs are combinational from State. PCWrite and IRWrite in FETCH, and the branch PCWrite, also depend on MemReady and Zero.
- ALUOp codes:
  - R=00000, ADDI=00001, ANDI=00010, ORI=00011, LUI=00100, LW=00101, SW=00110, BEQ=00111, BNE=01000.
  - States not listed below drive ALUOp=00001 (add).
- Supported opcodes: R 000000, ADDI 001000, ANDI 001100, ORI 001101, LUI 001111, LW 100011, SW 101011, BEQ 000100, BNE 000101, J 000010.
- Legal R Funct values: 100000, 100100, 100111, 100101, 000000, 000010.
- States and transitions:
  - FETCH(0): IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=1, ALUOp=00001, PCSource=0. IRWrite=PCWrite=MemReady. Go to DECODE when MemReady=1, else hold.
  - DECODE(1): ALUSrcA=0, ALUSrcB=3, ALUOp=00001 (branch target into ALUOut). Next state by Opcode:
    - LW/SW to MEMADR
    - R with legal Funct to REXEC; R with illegal Funct to TRAP
    - ADDI/ANDI/ORI/LUI to IEXEC
    - BEQ/BNE to BRANCH
    - J to JUMP
    - anything else to TRAP
  - MEMADR(2): ALUSrcA=1, ALUSrcB=2, ALUOp=00101 for LW, 00110 for SW. Go to MEMRD for LW, MEMWR for SW.
  - MEMRD(3): IorD=1, MemRead=1. Hold until MemReady=1, then go to MEMWB.
  - MEMWB(4): RegDst=0, MemtoReg=1, RegWrite=1, Retire=1. Go to FETCH.
  - MEMWR(5): IorD=1, MemWrite=1. Hold until MemReady=1; on that cycle Retire=1 and go to FETCH.
  - REXEC(6): ALUSrcA=1, ALUSrcB=0, ALUOp=00000. Go to RWB.
  - RWB(7): RegDst=1, MemtoReg=0, RegWrite=1, Retire=1. Go to FETCH.
  - BRANCH(8): ALUSrcA=1, ALUSrcB=0, ALUOp=00111 (BEQ) or 01000 (BNE), PCSource=1.
    - PCWrite = Zero for BEQ, ~Zero for BNE.
    - Retire=1. Go to FETCH.
  - JUMP(9): PCSource=2, PCWrite=1, Retire=1. Go to FETCH.
  - IEXEC(10): ALUSrcA=1, ALUSrcB=2, ALUOp per opcode. Go to IWB.
  - IWB(11): RegDst=0, MemtoReg=0, RegWrite=1, Retire=1. Go to FETCH.
  - TRAP(12): Illegal=1, all enables 0, Retire=0. Only reset leaves TRAP.
  - Codes 13-15 are unreachable; if entered, go to TRAP.
- Opcode and Funct are sampled only in DECODE, MEMADR, IEXEC and BRANCH. The IR is stable after FETCH.
- RetiredCount increments on each Retire cycle. It wraps from all-ones to 0.
- Latency with MemReady=1 throughout, counting cycles including FETCH:
  - R, I-type, SW: 4
  - LW: 5
  - BEQ/BNE, J: 3
  - Each MemReady=0 cycle adds one cycle.

Test Plan:
- Reset then ADD (Opcode=000000, Funct=100000), MemReady=1 -> States 0,1,6,7,0. ALUOp=00000 in REXEC. RegWrite and Retire in RWB only. RetiredCount=1.
- LW with MemReady low 2 cycles in MEMRD -> States 0,1,2,3,3,3,4. ALUOp=00101 in MEMADR. One RegWrite with MemtoReg=1.
- BEQ with Zero=1, then BNE with Zero=1 -> PCWrite=1, PCSource=1 for the BEQ. PCWrite=0 in BRANCH for the BNE. ALUOp=00111 then 01000. Both retire.
- Opcode=111111 at DECODE, then Funct=000001 R-type after reset -> TRAP (12), Illegal=1, no enables. Holds 20 cycles. reset=0 returns to FETCH with Illegal=0.
- Assert reset=0 in MEMWR with MemReady=1 -> MemWrite=0, Retire=0 that cycle. State=0 next cycle. RetiredCount=0.
- Preload behaviour with CNT_W=4: retire 16 ADDIs -> RetiredCount wraps to 0. ALUOp=00001 in IEXEC.

Source files
------------

// File: rtl/mips_multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch/decode/execute/
// memory/writeback, stalls on MemReady, and parks in a sticky TRAP on illegal encodings.
module mips_multicycle_control #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic [5:0]       Funct,
  input  logic             Zero,
  input  logic             MemReady,
  output logic [4:0]       ALUOp,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic [1:0]       PCSource,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             Retire,
  output logic [CNT_W-1:0] RetiredCount,
  output logic             Illegal,
  output logic [3:0]       State
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,  DECODE = 4'd1,  MEMADR = 4'd2,  MEMRD  = 4'd3,
    MEMWB  = 4'd4,  MEMWR  = 4'd5,  REXEC  = 4'd6,  RWB    = 4'd7,
    BRANCH = 4'd8,  JUMP   = 4'd9,  IEXEC  = 4'd10, IWB    = 4'd11,
    TRAP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;

  logic mem_read_c, mem_write_c, ir_write_c, pc_write_c, reg_write_c, retire_c;

  function automatic logic funct_legal(input logic [5:0] f);
    case (f)
      6'b100000, 6'b100100, 6'b100111, 6'b100101, 6'b000000, 6'b000010: funct_legal = 1'b1;
      default: funct_legal = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= FETCH;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (retire_c)
        cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

  always_comb begin
    state_next  = state_reg;
    ALUOp       = 5'b00001;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'd0;
    IorD        = 1'b0;
    PCSource    = 2'd0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    pc_write_c  = 1'b0;
    reg_write_c = 1'b0;
    retire_c    = 1'b0;
    case (state_reg)
      FETCH: begin
        mem_read_c = 1'b1;
        ALUSrcB    = 2'd1;
        ir_write_c = MemReady;
        pc_write_c = MemReady;
        if (MemReady) state_next = DECODE;
      end
      DECODE: begin
        ALUSrcB = 2'd3;
        case (Opcode)
          OP_LW, OP_SW:                     state_next = MEMADR;
          OP_R:                             state_next = funct_legal(Funct) ? REXEC : TRAP;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_next = IEXEC;
          OP_BEQ, OP_BNE:                   state_next = BRANCH;
          OP_J:                             state_next = JUMP;
          default:                          state_next = TRAP;
        endcase
      end
      MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'd2;
        ALUOp      = (Opcode == OP_LW) ? 5'b00101 : 5'b00110;
        state_next = (Opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        IorD       = 1'b1;
        mem_read_c = 1'b1;
        if (MemReady) state_next = MEMWB;
      end
      MEMWB: begin
        MemtoReg    = 1'b1;
        reg_write_c = 1'b1;
        retire_c    = 1'b1;
        state_next  = FETCH;
      end
      MEMWR: begin
        IorD        = 1'b1;
        mem_write_c = 1'b1;
        if (MemReady) begin
          retire_c   = 1'b1;
          state_next = FETCH;
        end
      end
      REXEC: begin
        ALUSrcA    = 1'b1;
        ALUOp      = 5'b00000;
        state_next = RWB;
      end
      RWB: begin
        RegDst      = 1'b1;
        reg_write_c = 1'b1;
        retire_c    = 1'b1;
        state_next  = FETCH;
      end
      BRANCH: begin
        ALUSrcA    = 1'b1;
        PCSource   = 2'd1;
        ALUOp      = (Opcode == OP_BNE) ? 5'b01000 : 5'b00111;
        pc_write_c = (Opcode == OP_BNE) ? ~Zero : Zero;
        retire_c   = 1'b1;
        state_next = FETCH;
      end
      JUMP: begin
        PCSource   = 2'd2;
        pc_write_c = 1'b1;
        retire_c   = 1'b1;
        state_next = FETCH;
      end
      IEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'd2;
        case (Opcode)
          OP_ANDI: ALUOp = 5'b00010;
          OP_ORI:  ALUOp = 5'b00011;
          OP_LUI:  ALUOp = 5'b00100;
          default: ALUOp = 5'b00001;
        endcase
        state_next = IWB;
      end
      IWB: begin
        reg_write_c = 1'b1;
        retire_c    = 1'b1;
        state_next  = FETCH;
      end
      TRAP:    state_next = TRAP;
      default: state_next = TRAP;
    endcase
  end

  // Reset gates every write enable so an abandoned instruction leaves no side effects.
  assign MemRead      = mem_read_c  & reset;
  assign MemWrite     = mem_write_c & reset;
  assign IRWrite      = ir_write_c  & reset;
  assign PCWrite      = pc_write_c  & reset;
  assign RegWrite     = reg_write_c & reset;
  assign Retire       = retire_c    & reset;
  assign RetiredCount = cnt_reg;
  assign Illegal      = (state_reg == TRAP);
  assign State        = state_reg;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Scoreboard bench for mips_multicycle_control: per-cycle expected states are queued
// with their MemReady stimulus, then popped and compared against the DUT.
module tb_mips_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] Opcode, Funct;
  logic       Zero, MemReady;
  logic [4:0] ALUOp;
  logic       ALUSrcA, IorD, MemRead, MemWrite, IRWrite, PCWrite;
  logic [1:0] ALUSrcB, PCSource;
  logic       RegDst, MemtoReg, RegWrite, Retire, Illegal;
  logic [3:0] RetiredCount;
  logic [3:0] State;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] st;
    logic       mr;
  } item_t;
  item_t sbq[$];

  mips_multicycle_control #(.CNT_W(4)) dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct), .Zero(Zero),
    .MemReady(MemReady), .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .PCWrite(PCWrite), .PCSource(PCSource), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .RegWrite(RegWrite), .Retire(Retire), .RetiredCount(RetiredCount),
    .Illegal(Illegal), .State(State)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic push(input logic [3:0] st, input logic mr);
    item_t it;
    it.st = st;
    it.mr = mr;
    sbq.push_back(it);
  endtask

  task automatic test_reset;
    reset = 1'b0; Opcode = 6'b000000; Funct = 6'b100000; Zero = 1'b0; MemReady = 1'b1;
    tick(); tick();
    #1;
    total++; if (State !== 4'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", State); end
    total++; if (RetiredCount !== 4'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", RetiredCount); end
    total++; if (Illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal: got %0b want 0", Illegal); end
    total++; if ({MemRead, IRWrite, PCWrite} !== 3'b000) begin bad++; $display("FAIL reset_enables: got %b want 000", {MemRead, IRWrite, PCWrite}); end
    reset = 1'b1;
    tick();
    $display("reset: state=%0d count=%0d", State, RetiredCount);
  endtask

  task automatic test_add;
    int regw = 0;
    do_reset();
    Opcode = 6'b000000; Funct = 6'b100000;
    push(4'd0, 1'b1); push(4'd1, 1'b1); push(4'd6, 1'b1); push(4'd7, 1'b1);
    while (sbq.size() > 0) begin
      item_t it = sbq.pop_front();
      MemReady = it.mr;
      #1;
      total++; if (State !== it.st) begin bad++; $display("FAIL add_state: got %0d want %0d", State, it.st); end
      if (it.st == 4'd6) begin
        total++; if (ALUOp !== 5'b00000) begin bad++; $display("FAIL add_aluop: got %b want 00000", ALUOp); end
      end
      total++; if ({RegWrite, Retire} !== {2{it.st == 4'd7}}) begin bad++; $display("FAIL add_wr_retire: got %b in state %0d", {RegWrite, Retire}, it.st); end
      if (RegWrite === 1'b1) regw++;
      tick();
    end
    total++; if (State !== 4'd0) begin bad++; $display("FAIL add_end_state: got %0d want 0", State); end
    total++; if (RetiredCount !== 4'd1) begin bad++; $display("FAIL add_count: got %0d want 1", RetiredCount); end
    $display("add: regwrites=%0d count=%0d", regw, RetiredCount);
  endtask

  task automatic test_lw_stall;
    int regw = 0;
    do_reset();
    Opcode = 6'b100011; Funct = 6'b000000;
    push(4'd0, 1'b1); push(4'd1, 1'b1); push(4'd2, 1'b1);
    push(4'd3, 1'b0); push(4'd3, 1'b0); push(4'd3, 1'b1); push(4'd4, 1'b1);
    while (sbq.size() > 0) begin
      item_t it = sbq.pop_front();
      MemReady = it.mr;
      #1;
      total++; if (State !== it.st) begin bad++; $display("FAIL lw_state: got %0d want %0d", State, it.st); end
      if (it.st == 4'd2) begin
        total++; if (ALUOp !== 5'b00101) begin bad++; $display("FAIL lw_aluop: got %b want 00101", ALUOp); end
      end
      if (it.st == 4'd3) begin
        total++; if ({IorD, MemRead} !== 2'b11) begin bad++; $display("FAIL lw_memrd: got %b want 11", {IorD, MemRead}); end
      end
      if (RegWrite === 1'b1) begin
        regw++;
        total++; if (MemtoReg !== 1'b1) begin bad++; $display("FAIL lw_memtoreg: got %b want 1", MemtoReg); end
      end
      tick();
    end
    total++; if (regw !== 1) begin bad++; $display("FAIL lw_regwrites: got %0d want 1", regw); end
    total++; if (RetiredCount !== 4'd1) begin bad++; $display("FAIL lw_count: got %0d want 1", RetiredCount); end
    $display("lw: regwrites=%0d count=%0d", regw, RetiredCount);
  endtask

  task automatic test_branch;
    logic [5:0] ops [2];
    ops[0] = 6'b000100; ops[1] = 6'b000101;
    do_reset();
    Zero = 1'b1; MemReady = 1'b1;
    for (int k = 0; k < 2; k++) begin
      Opcode = ops[k];
      push(4'd0, 1'b1); push(4'd1, 1'b1); push(4'd8, 1'b1);
      while (sbq.size() > 0) begin
        item_t it = sbq.pop_front();
        MemReady = it.mr;
        #1;
        total++; if (State !== it.st) begin bad++; $display("FAIL br_state: got %0d want %0d", State, it.st); end
        if (it.st == 4'd8) begin
          total++; if (PCWrite !== (k == 0)) begin bad++; $display("FAIL br_pcwrite: got %b want %b", PCWrite, (k == 0)); end
          total++; if (PCSource !== 2'd1) begin bad++; $display("FAIL br_pcsource: got %0d want 1", PCSource); end
          total++; if (ALUOp !== ((k == 0) ? 5'b00111 : 5'b01000)) begin bad++; $display("FAIL br_aluop: got %b", ALUOp); end
          total++; if (Retire !== 1'b1) begin bad++; $display("FAIL br_retire: got %b want 1", Retire); end
        end
        tick();
      end
      $display("branch %0d: count=%0d", k, RetiredCount);
    end
    total++; if (RetiredCount !== 4'd2) begin bad++; $display("FAIL br_count: got %0d want 2", RetiredCount); end
    Zero = 1'b0;
  endtask

  task automatic test_jump_ori;
    do_reset();
    Opcode = 6'b000010;
    push(4'd0, 1'b1); push(4'd1, 1'b1); push(4'd9, 1'b1);
    while (sbq.size() > 0) begin
      item_t it = sbq.pop_front();
      MemReady = it.mr;
      #1;
      total++; if (State !== it.st) begin bad++; $display("FAIL j_state: got %0d want %0d", State, it.st); end
      if (it.st == 4'd9) begin
        total++; if ({PCWrite, PCSource} !== 3'b110) begin bad++; $display("FAIL j_pc: got %b want 110", {PCWrite, PCSource}); end
      end
      tick();
    end
    Opcode = 6'b001101;
    push(4'd0, 1'b1); push(4'd1, 1'b1); push(4'd10, 1'b1); push(4'd11, 1'b1);
    while (sbq.size() > 0) begin
      item_t it = sbq.pop_front();
      MemReady = it.mr;
      #1;
      total++; if (State !== it.st) begin bad++; $display("FAIL ori_state: got %0d want %0d", State, it.st); end
      if (it.st == 4'd10) begin
        total++; if (ALUOp !== 5'b00011) begin bad++; $display("FAIL ori_aluop: got %b want 00011", ALUOp); end
      end
      tick();
    end
    total++; if (RetiredCount !== 4'd2) begin bad++; $display("FAIL jori_count: got %0d want 2", RetiredCount); end
    $display("jump+ori: count=%0d", RetiredCount);
  endtask

  task automatic test_trap;
    logic [5:0] ops [2];
    logic [5:0] fns [2];
    ops[0] = 6'b111111; fns[0] = 6'b100000;
    ops[1] = 6'b000000; fns[1] = 6'b000001;
    for (int k = 0; k < 2; k++) begin
      do_reset();
      Opcode = ops[k]; Funct = fns[k];
      push(4'd0, 1'b1); push(4'd1, 1'b1);
      for (int c = 0; c < 20; c++) push(4'd12, 1'b1);
      while (sbq.size() > 0) begin
        item_t it = sbq.pop_front();
        MemReady = it.mr;
        #1;
        total++; if (State !== it.st) begin bad++; $display("FAIL trap_state: got %0d want %0d", State, it.st); end
        if (it.st == 4'd12) begin
          total++; if (Illegal !== 1'b1) begin bad++; $display("FAIL trap_illegal: got %b want 1", Illegal); end
          total++; if ({MemRead, MemWrite, IRWrite, PCWrite, RegWrite, Retire} !== 6'b0) begin
            bad++; $display("FAIL trap_enables: got %b want 000000", {MemRead, MemWrite, IRWrite, PCWrite, RegWrite, Retire});
          end
        end
        tick();
      end
      do_reset();
      #1;
      total++; if (State !== 4'd0) begin bad++; $display("FAIL trap_exit_state: got %0d want 0", State); end
      total++; if (Illegal !== 1'b0) begin bad++; $display("FAIL trap_exit_illegal: got %b want 0", Illegal); end
      $display("trap %0d: exited to state=%0d illegal=%b", k, State, Illegal);
      tick();
    end
  endtask

  task automatic test_reset_in_memwr;
    do_reset();
    Opcode = 6'b101011; Funct = 6'b000000;
    push(4'd0, 1'b1); push(4'd1, 1'b1); push(4'd2, 1'b1);
    while (sbq.size() > 0) begin
      item_t it = sbq.pop_front();
      MemReady = it.mr;
      #1;
      total++; if (State !== it.st) begin bad++; $display("FAIL sw_state: got %0d want %0d", State, it.st); end
      tick();
    end
    MemReady = 1'b0;
    #1;
    total++; if ({State, MemWrite, Retire} !== {4'd5, 1'b1, 1'b0}) begin bad++; $display("FAIL sw_stall: got st=%0d mw=%b rt=%b", State, MemWrite, Retire); end
    tick();
    reset = 1'b0; MemReady = 1'b1;
    #1;
    total++; if ({MemWrite, Retire} !== 2'b00) begin bad++; $display("FAIL sw_reset_gate: got %b want 00", {MemWrite, Retire}); end
    tick();
    reset = 1'b1;
    total++; if (State !== 4'd0) begin bad++; $display("FAIL sw_reset_state: got %0d want 0", State); end
    total++; if (RetiredCount !== 4'd0) begin bad++; $display("FAIL sw_reset_count: got %0d want 0", RetiredCount); end
    $display("sw reset: state=%0d count=%0d", State, RetiredCount);
  endtask

  task automatic test_wrap;
    do_reset();
    Opcode = 6'b001000; MemReady = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      push(4'd0, 1'b1); push(4'd1, 1'b1); push(4'd10, 1'b1); push(4'd11, 1'b1);
      while (sbq.size() > 0) begin
        item_t it = sbq.pop_front();
        MemReady = it.mr;
        #1;
        total++; if (State !== it.st) begin bad++; $display("FAIL addi_state: got %0d want %0d", State, it.st); end
        if (it.st == 4'd10) begin
          total++; if (ALUOp !== 5'b00001) begin bad++; $display("FAIL addi_aluop: got %b want 00001", ALUOp); end
        end
        tick();
      end
      total++; if (RetiredCount !== 4'(n)) begin bad++; $display("FAIL addi_count: got %0d want %0d", RetiredCount, 4'(n)); end
      $display("addi %0d: count=%0d", n, RetiredCount);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_stall();
    test_branch();
    test_jump_ori();
    test_trap();
    test_reset_in_memwr();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
